shared_vector_matrix_memory: RTL and testbench

- Responder end of the accelerator's shared-memory interface; the memory controller is the initiator.
- Port A is a vector store of VEC_DEPTH words × VECTOR_WIDTH bits. Port B is a matrix store of MAT_DEPTH entries × 2 bits.
- Detects new commands from the controller's held address/write-enable/data lines and stalls it with mem_busy for a fixed access latency.
- Commits writes, returns read data, and reports range and conflict errors on mem_error.

---
 rtl/shared_vector_matrix_memory.sv | 145 ++++++++++++++
 tb/tb_shared_vector_matrix_memory.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_vector_matrix_memory.sv
// Shared-memory responder: vector store on port A, 2-bit matrix store on port B, busy-stalled accesses.
// Optional per-word even parity on the vector store is enabled with `define SHMEM_PARITY_EN.
module shared_vector_matrix_memory #(
    parameter int unsigned VECTOR_WIDTH   = 32,
    parameter int unsigned VEC_DEPTH      = 64,
    parameter int unsigned MAT_DEPTH      = 256,
    parameter int unsigned ACCESS_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              mem_addr_a,
    input  logic                    mem_we_a,
    input  logic [VECTOR_WIDTH-1:0] mem_wdata_a,
    output logic [VECTOR_WIDTH-1:0] mem_rdata_a,
    input  logic [7:0]              mem_addr_b,
    input  logic                    mem_we_b,
    input  logic [1:0]              mem_wdata_b,
    output logic [1:0]              mem_rdata_b,
    output logic                    mem_busy,
    output logic [1:0]              mem_error
`ifdef SHMEM_PARITY_EN
    ,
    input  logic                    parity_inject
`endif
);

    localparam int unsigned TW = VECTOR_WIDTH + 18;
    localparam int unsigned CW = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [TW-1:0]           cur, last, acc;
    logic                    last_valid;
    logic                    is_new, capture, do_access;
    logic [5:0]              acc_addr_a;
    logic                    acc_we_a;
    logic [VECTOR_WIDTH-1:0] acc_wdata_a;
    logic [7:0]              acc_addr_b;
    logic                    acc_we_b;
    logic [1:0]              acc_wdata_b;
    logic                    err_range, err_conf, access_ok, par_err;

    logic [VECTOR_WIDTH-1:0] vec [64];
    logic [1:0]              mat [256];
`ifdef SHMEM_PARITY_EN
    logic                    vec_par [64];
`endif

    assign cur    = {mem_addr_a, mem_we_a, mem_wdata_a, mem_addr_b, mem_we_b, mem_wdata_b};
    assign is_new = !last_valid || (cur != last);
    // The last accepted tuple doubles as the captured command while BUSY.
    assign acc    = (state == BUSY) ? last : cur;

    assign acc_addr_a  = acc[TW-1 -: 6];
    assign acc_we_a    = acc[TW-7];
    assign acc_wdata_a = acc[TW-8 -: VECTOR_WIDTH];
    assign acc_addr_b  = acc[10:3];
    assign acc_we_b    = acc[2];
    assign acc_wdata_b = acc[1:0];

    assign err_range = ({1'b0, acc_addr_a} >= 7'(VEC_DEPTH)) || ({1'b0, acc_addr_b} >= 9'(MAT_DEPTH));
    assign err_conf  = acc_we_a & acc_we_b;
    assign access_ok = !err_range && !err_conf;

`ifdef SHMEM_PARITY_EN
    assign par_err = !acc_we_a && ((^vec[acc_addr_a]) != vec_par[acc_addr_a]);
`else
    assign par_err = 1'b0;
`endif

    assign mem_busy = (state == BUSY) || is_new;

    // Counter loads LATENCY-1 at capture and the access fires as it steps to zero,
    // so a LATENCY of 1 commits straight from IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (is_new) begin
                    capture = 1'b1;
                    if (ACCESS_LATENCY == 1) begin
                        do_access = 1'b1;
                    end else begin
                        cnt_nxt   = CW'(ACCESS_LATENCY - 1);
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    do_access = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= '0;
            last_valid  <= 1'b0;
            mem_rdata_a <= '0;
            mem_rdata_b <= '0;
            mem_error   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_error <= '0;
            if (capture) begin
                last       <= cur;
                last_valid <= 1'b1;
            end
            if (do_access) begin
                mem_error <= {err_conf, err_range};
                if (access_ok) begin
                    if (!acc_we_a) mem_rdata_a <= vec[acc_addr_a];
                    if (!acc_we_b) mem_rdata_b <= mat[acc_addr_b];
                    if (par_err)   mem_error   <= 2'b11;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_access && access_ok) begin
            if (acc_we_a) begin
                vec[acc_addr_a] <= acc_wdata_a;
`ifdef SHMEM_PARITY_EN
                vec_par[acc_addr_a] <= (^acc_wdata_a) ^ parity_inject;
`endif
            end
            if (acc_we_b) mat[acc_addr_b] <= acc_wdata_b;
        end
    end

endmodule

// File: tb/tb_shared_vector_matrix_memory.sv
// Bench for shared_vector_matrix_memory: directed plan steps followed by random commands
// checked against an array-based model of the command/latency/error rules.
module tb_shared_vector_matrix_memory;

    localparam int unsigned VW = 32;
    localparam int unsigned VD = 32;
    localparam int unsigned MD = 240;
    localparam int unsigned L  = 2;
`ifdef SHMEM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    mem_addr_a;
    logic          mem_we_a;
    logic [VW-1:0] mem_wdata_a;
    logic [VW-1:0] mem_rdata_a;
    logic [7:0]    mem_addr_b;
    logic          mem_we_b;
    logic [1:0]    mem_wdata_b;
    logic [1:0]    mem_rdata_b;
    logic          mem_busy;
    logic [1:0]    mem_error;
`ifdef SHMEM_PARITY_EN
    logic          parity_inject;
`endif

    shared_vector_matrix_memory #(
        .VECTOR_WIDTH  (VW),
        .VEC_DEPTH     (VD),
        .MAT_DEPTH     (MD),
        .ACCESS_LATENCY(L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr_a (mem_addr_a),
        .mem_we_a   (mem_we_a),
        .mem_wdata_a(mem_wdata_a),
        .mem_rdata_a(mem_rdata_a),
        .mem_addr_b (mem_addr_b),
        .mem_we_b   (mem_we_b),
        .mem_wdata_b(mem_wdata_b),
        .mem_rdata_b(mem_rdata_b),
        .mem_busy   (mem_busy),
        .mem_error  (mem_error)
`ifdef SHMEM_PARITY_EN
        ,
        .parity_inject(parity_inject)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    logic [VW-1:0] m_vec [64];
    bit            m_vk  [64];
    bit            m_bad [64];
    logic [1:0]    m_mat [256];
    bit            m_mk  [256];
    logic [VW-1:0] m_rda;
    bit            m_rda_k;
    logic [1:0]    m_rdb;
    bit            m_rdb_k;
    logic [VW+17:0] m_last;
    bit            m_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] aa, input logic wea, input logic [VW-1:0] wda,
                         input logic [7:0] ab, input logic web, input logic [1:0] wdb, input logic inj);
        mem_addr_a  = aa;
        mem_we_a    = wea;
        mem_wdata_a = wda;
        mem_addr_b  = ab;
        mem_we_b    = web;
        mem_wdata_b = wdb;
`ifdef SHMEM_PARITY_EN
        parity_inject = inj;
`endif
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_rda   = '0;
        m_rda_k = 1'b1;
        m_rdb   = '0;
        m_rdb_k = 1'b1;
    endtask

    task automatic chk_rdata(input string tag);
        if (m_rda_k) chk({tag, "_rdata_a"}, 64'(mem_rdata_a), 64'(m_rda));
        if (m_rdb_k) chk({tag, "_rdata_b"}, 64'(mem_rdata_b), 64'(m_rdb));
    endtask

    // Present one command (caller is just after a falling edge) and follow it to completion.
    task automatic do_cmd(input logic [5:0] aa, input logic wea, input logic [VW-1:0] wda,
                          input logic [7:0] ab, input logic web, input logic [1:0] wdb,
                          input logic inj, input bit perturb);
        logic [VW+17:0] t;
        logic [1:0]     e;
        bit             nw, e_k;
        t  = {aa, wea, wda, ab, web, wdb};
        drive(aa, wea, wda, ab, web, wdb, inj);
        nw = !m_valid || (t != m_last);
        #1 chk("busy_start", 64'(mem_busy), 64'(nw));
        if (nw) begin
            m_valid = 1'b1;
            m_last  = t;
            for (int unsigned k = 1; k < L; k++) begin
                @(negedge clk);
                if (perturb)
                    drive(6'($urandom), 1'($urandom), $urandom, 8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
                #1 chk("busy_hold", 64'(mem_busy), 64'(1));
                chk("err_during_busy", 64'(mem_error), 64'(0));
            end
            @(negedge clk);
            if (perturb) drive(aa, wea, wda, ab, web, wdb, inj);
            e   = {wea && web, (aa >= VD) || (ab >= MD)};
            e_k = 1'b1;
            if (e == 2'b00) begin
                if (wea) begin
                    m_vec[aa] = wda;
                    m_vk[aa]  = 1'b1;
                    m_bad[aa] = PAR && inj;
                end else begin
                    m_rda   = m_vec[aa];
                    m_rda_k = m_vk[aa];
                    e_k     = m_vk[aa];
                    if (m_bad[aa]) e = 2'b11;
                end
                if (web) begin
                    m_mat[ab] = wdb;
                    m_mk[ab]  = 1'b1;
                end else begin
                    m_rdb   = m_mat[ab];
                    m_rdb_k = m_mk[ab];
                end
            end
            #1 chk("busy_done", 64'(mem_busy), 64'(0));
            if (e_k) chk("err_pulse", 64'(mem_error), 64'(e));
            chk_rdata("done");
            @(negedge clk);
            #1 chk("err_clear", 64'(mem_error), 64'(0));
        end else begin
            @(negedge clk);
            #1 chk("busy_repeat", 64'(mem_busy), 64'(0));
            chk("err_repeat", 64'(mem_error), 64'(0));
            chk_rdata("repeat");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]    pa;
        logic          pwea, pweb, pinj;
        logic [VW-1:0] pwda;
        logic [7:0]    pab;
        logic [1:0]    pwdb;
        logic [VW-1:0] old7;

        foreach (m_vk[i])  m_vk[i]  = 1'b0;
        foreach (m_bad[i]) m_bad[i] = 1'b0;
        foreach (m_mk[i])  m_mk[i]  = 1'b0;
        model_reset();

        rst_n = 1'b0;
        drive(6'd5, 1'b1, 32'hDEADBEEF, 8'd0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        #1 chk("reset_rdata_a", 64'(mem_rdata_a), 64'(0));
        chk("reset_rdata_b", 64'(mem_rdata_b), 64'(0));
        chk("reset_error", 64'(mem_error), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_cmd(6'd5, 1'b1, 32'hDEADBEEF, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        do_cmd(6'd5, 1'b0, '0, 8'd0, 1'b0, 2'b00, 1'b0, 1'b0);
        do_cmd(6'd5, 1'b0, '0, 8'd200, 1'b1, 2'b10, 1'b0, 1'b0);
        do_cmd(6'd5, 1'b0, '0, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        do_cmd(6'd40, 1'b0, '0, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        do_cmd(6'd5, 1'b1, 32'h12345678, 8'd200, 1'b1, 2'b01, 1'b0, 1'b0);
        do_cmd(6'd5, 1'b0, '0, 8'd200, 1'b0, 2'b00, 1'b0, 1'b1);

        do_cmd(6'd9, 1'b1, 32'hCAFEF00D, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk("hold_no_busy", 64'(mem_busy), 64'(0));
        end

        old7 = 32'h0BADF00D;
        do_cmd(6'd7, 1'b1, old7, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        drive(6'd7, 1'b1, 32'h55AA55AA, 8'd200, 1'b0, 2'b00, 1'b0);
        #1 chk("abort_busy", 64'(mem_busy), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 chk("abort_rdata_a", 64'(mem_rdata_a), 64'(0));
        chk("abort_rdata_b", 64'(mem_rdata_b), 64'(0));
        chk("abort_error", 64'(mem_error), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(6'd7, 1'b0, '0, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("abort_old_value", 64'(mem_rdata_a), 64'(old7));

        do_cmd(6'd3, 1'b1, $urandom, 8'd200, 1'b0, 2'b00, 1'b1, 1'b0);
        do_cmd(6'd3, 1'b0, '0, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < VD; i++)
            do_cmd(6'(i), 1'b1, $urandom, 8'd200, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < MD; i++)
            do_cmd(6'(i % VD), 1'b0, '0, 8'(i), 1'b1, 2'($urandom), 1'b0, 1'b0);

        pa = 6'd1; pwea = 1'b0; pwda = '0; pab = 8'd1; pweb = 1'b0; pwdb = 2'b00; pinj = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) != 0) begin
                pa   = 6'($urandom_range(0, VD + 7));
                pwea = 1'($urandom_range(0, 1));
                pwda = $urandom;
                pab  = 8'($urandom_range(0, MD + 15));
                pweb = ($urandom_range(0, 2) == 0);
                pwdb = 2'($urandom);
                pinj = ($urandom_range(0, 7) == 0);
            end
            do_cmd(pa, pwea, pwda, pab, pweb, pwdb, pinj, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
